// File: rtl/hazard_controller.sv
// Hazard/sequencing control for the 5-stage core: forwarding selects, stall/flush, memory wait FSM.
// Latency: stall/flush/forward are combinational; FSM state, timeout and stall counter are registered.
// Backpressure: a busy data memory freezes F..M and bubbles W until MemReadyM rises.
module hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemTimeout,
  output logic [CNT_W-1:0]      StallCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              mem_stall;
  logic              lw_stall;

  // M-stage result is younger than W, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = LoadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // wcnt counts not-ready cycles of the current access; ERR once MEM_TIMEOUT of them have elapsed.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
          if (wcnt == WCNT_W'(MEM_TIMEOUT - 1)) state_nxt = S_ERR;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: begin
        state_nxt = S_IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  assign MemTimeout = (state == S_ERR);
  assign mem_stall  = MemTimeout || (MemReqM && !MemReadyM);

  // A memory stall freezes D and E, so branch/load-use decisions are simply re-taken after release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           StallCount <= '0;
    else if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed + random checks of hazard_controller against a behavioural model.
module tb_hazard_controller;
  localparam int RW = 5;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE, fa4, fb4;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic          sf4, sd4, se4, sm4, fd4, fe4, fw4, mt4;
  logic [15:0]   StallCount;
  logic [3:0]    StallCount4;

  int errors = 0;
  int checks = 0;

  // model state
  bit m_err;
  int m_run;
  int m_cnt;

  always #5 clk = ~clk;

  hazard_controller #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount));

  hazard_controller #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4),
    .StallE(se4), .StallM(sm4), .FlushD(fd4), .FlushE(fe4), .FlushW(fw4),
    .MemTimeout(mt4), .StallCount(StallCount4));

  function automatic logic [1:0] exp_fwd(logic [RW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] exp_ctl();
    bit mem, lw;
    mem = m_err || (MemReqM && !MemReadyM);
    lw  = LoadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    if (mem)    return 7'b1111001;
    if (PCSrcE) return 7'b0000110;
    if (lw)     return 7'b1100010;
    return 7'b0000000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".fwdA"}, 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
    chk({tag, ".fwdB"}, 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
    chk({tag, ".ctl"}, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(exp_ctl()));
    chk({tag, ".timeout"}, 32'(MemTimeout), 32'(m_err));
    chk({tag, ".cnt16"}, 32'(StallCount), 32'(m_cnt > 65535 ? 65535 : m_cnt));
    chk({tag, ".cnt4"}, 32'(StallCount4), 32'(m_cnt > 15 ? 15 : m_cnt));
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_run = 0;
    m_cnt = 0;
  endtask

  // Access is "in progress" once a not-ready cycle has been seen; it ends on ready.
  task automatic model_edge();
    bit sf;
    sf = exp_ctl()[6];
    if (sf) m_cnt++;
    if (!m_err) begin
      if ((m_run > 0 && !MemReadyM) || (m_run == 0 && MemReqM && !MemReadyM)) m_run++;
      else m_run = 0;
      if (m_run >= TO) m_err = 1'b1;
    end
  endtask

  // called at a negedge with inputs already driven
  task automatic step(string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("por");
    reset = 1'b0;
    @(negedge clk);

    // forwarding priority and x0
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1 chk("fwd_m", 32'(ForwardAE), 32'h2);
    step("fwd_m");
    RegWriteM = 0;
    #1 chk("fwd_w", 32'(ForwardAE), 32'h1);
    step("fwd_w");
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    #1 chk("fwd_x0", 32'(ForwardAE), 32'h0);
    step("fwd_x0");
    Rs2E = 3; RdW = 3; RdM = 4;
    step("fwd_b_w");
    clear_inputs();

    // load-use
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1 chk("lw_ctl", 32'({StallF, StallD, FlushE}), 32'h7);
    step("lw");
    chk("lw_cnt", 32'(StallCount), 32'd1);
    Rs2D = 8;
    step("lw_none");
    clear_inputs();

    // taken branch
    PCSrcE = 1;
    step("br");
    chk("br_cnt", 32'(StallCount), 32'd1);
    PCSrcE = 1; LoadE = 1; RdE = 9; Rs1D = 9;
    step("br_lw");
    clear_inputs();

    // 3-cycle memory wait, branch during the wait is held off
    MemReqM = 1; MemReadyM = 0;
    step("mw1");
    PCSrcE = 1;
    #1 chk("mw_noflushd", 32'(FlushD), 32'h0);
    step("mw2");
    PCSrcE = 0;
    step("mw3");
    MemReadyM = 1;
    #1 chk("mw_release", 32'(StallF), 32'h0);
    step("mw_rdy");
    chk("mw_cnt", 32'(StallCount), 32'd4);
    MemReadyM = 1;
    step("zero_wait");
    clear_inputs();

    // saturation of the narrow counter
    do_reset();
    LoadE = 1; RdE = 7; Rs1D = 7;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat4", 32'(StallCount4), 32'd15);
    chk("sat16", 32'(StallCount), 32'd20);
    clear_inputs();

    // timeout
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 14; i++) step("to");
    chk("to_lo", 32'(MemTimeout), 32'h0);
    step("to15");
    chk("to_hi", 32'(MemTimeout), 32'h1);
    MemReqM = 0; MemReadyM = 1;
    for (int i = 0; i < 5; i++) step("err_hold");

    // asynchronous reset mid-ERR, away from any clock edge
    #2 reset = 1'b1;
    #1 chk("async_to", 32'(MemTimeout), 32'h0);
    chk("async_cnt", 32'(StallCount), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step("post_rst");

    // random
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 59) begin
        clear_inputs();
        do_reset();
      end
      Rs1D = RW'($urandom_range(0, 3)); Rs2D = RW'($urandom_range(0, 3));
      Rs1E = RW'($urandom_range(0, 3)); Rs2E = RW'($urandom_range(0, 3));
      RdE  = RW'($urandom_range(0, 3)); RdM  = RW'($urandom_range(0, 3));
      RdW  = RW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom % 2); RegWriteW = 1'($urandom % 2);
      LoadE = ($urandom % 3) == 0; PCSrcE = ($urandom % 6) == 0;
      MemReqM = 1'($urandom % 2); MemReadyM = ($urandom % 3) != 0;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core (F/D/E/M/W). It generates the operand-forwarding selects for the execute stage, and the stall and flush controls for the pipeline registers, covering load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses. A memory wait-state FSM holds the pipeline while memory is busy and flags a timeout. A saturating stall-cycle counter supports performance measurement.

Parameters:
REG_ADDR_W, 5, register index width
MEM_TIMEOUT, 15, maximum consecutive wait cycles on a memory access before the error state (range 2..255)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in Decode
Rs1E, Rs2E  in  REG_ADDR_W  source registers of the instruction in Execute
RdE, RdM, RdW  in  REG_ADDR_W  destination registers in E/M/W
RegWriteM, RegWriteW  in  1  register-write enable of the M and W instructions
LoadE  in  1  instruction in E is a load (ResultSrcE == 2'b01)
PCSrcE  in  1  taken branch, jal or jalr resolved in E
MemReqM  in  1  load or store active in M
MemReadyM  in  1  data memory completes the M access this cycle
ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  out  1  load a bubble into the corresponding pipeline register
MemTimeout  out  1  sticky error: memory never became ready
StallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE is identical, using Rs2E.
  - M has priority over W. x0 is never forwarded.
- Load-use hazard: lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Memory FSM (registered state, wait counter width ceil(log2(MEM_TIMEOUT+1))):
  - IDLE: if MemReqM & !MemReadyM, go to WAIT with cnt=1. Otherwise stay.
  - WAIT: if MemReadyM, go to IDLE with cnt=0. Else cnt++. When cnt==MEM_TIMEOUT with MemReadyM still low, go to ERR.
  - ERR: absorbing until reset. MemTimeout=1.
  - Zero-wait accesses (MemReadyM high in the request cycle) never leave IDLE and add no stall.
- memStall (combinational) = (state!=ERR & MemReqM & !MemReadyM) | state==ERR.
  - Stall asserts in the first not-ready cycle.
  - Stall releases in the same cycle that MemReadyM rises.
- Output priority:
  - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored; they re-evaluate after release because D and E are frozen.
  - Else lwStall: StallF=StallD=1, FlushE=1.
  - PCSrcE: FlushD=1, FlushE=1.
  - lwStall and PCSrcE cannot be simultaneously true (E holds one instruction). If both assert, PCSrcE wins: StallF=StallD=0, FlushD=FlushE=1.
  - StallE and StallM are asserted only by memStall. FlushW is asserted only by memStall.
- StallCount:
  - Increments on each clk edge where StallF=1.
  - Saturates at all-ones.
  - Not cleared by anything except reset.
- Reset (asynchronous, immediate): state=IDLE, cnt=0, MemTimeout=0, StallCount=0. Combinational outputs follow inputs in IDLE.
- Reset asserted mid-WAIT or in ERR returns to IDLE in the same instant. There is no residual stall after deassertion unless MemReqM & !MemReadyM.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RdM=RdW=Rs1E=0 -> ForwardAE=00.
- LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. StallCount increments by 1. Rs2D=8 -> no stall.
- PCSrcE=1 pulse -> FlushD=FlushE=1, StallF=0, StallCount unchanged.
- MemReqM=1 with MemReadyM low for 3 cycles, then high -> StallF/D/E/M and FlushW high for exactly 3 cycles. FSM goes IDLE→WAIT→IDLE. StallCount +=3. PCSrcE=1 during the wait -> FlushD=0.
- MemReqM=1, MemReadyM=0 held for 20 cycles (MEM_TIMEOUT=15) -> MemTimeout rises after cycle 15 and stays high with permanent stall. Assert reset -> MemTimeout=0 and StallCount=0 immediately, without a clock edge.
- CNT_W=4 with 20 consecutive stall cycles -> StallCount stops at 15.
